// File: rtl/subservient_gpio_bank.sv
// subservient_gpio_bank: Wishbone-slave GPIO bank with synchronised inputs and maskable edge interrupts
module subservient_gpio_bank #(
    parameter int          NGPIO       = 8,
    parameter int          NIRQ        = 3,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             wbs_stb_i,
    input  logic             wbs_cyc_i,
    input  logic             wbs_we_i,
    input  logic [3:0]       wbs_sel_i,
    input  logic [31:0]      wbs_dat_i,
    input  logic [31:0]      wbs_adr_i,
    output logic             wbs_ack_o,
    output logic [31:0]      wbs_dat_o,
    input  logic [NGPIO-1:0] io_in,
    output logic [NGPIO-1:0] io_out,
    output logic [NGPIO-1:0] io_oeb,
    output logic [NIRQ-1:0]  irq
);
    logic [NGPIO-1:0]             out_r, dir_r, ie_r, edge_r, stat_r, prev_r;
    logic [SYNC_STAGES*NGPIO-1:0] sync_r;
    logic                         ack_r;
    logic [31:0]                  lane, rd;
    logic [NGPIO-1:0]             in_v, wmask, wdat, hit, w1c;
    logic [5:0]                   ofs;
    logic                         hit_bus, wr;
    logic                         unused;

    assign hit_bus = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign wr      = ack_r & hit_bus & wbs_we_i;
    assign ofs     = wbs_adr_i[7:2];
    assign lane    = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
    assign wmask   = lane[NGPIO-1:0];
    assign wdat    = wbs_dat_i[NGPIO-1:0];
    assign in_v    = sync_r[SYNC_STAGES*NGPIO-1 -: NGPIO];
    assign hit     = ie_r & ((edge_r & in_v & ~prev_r) | (~edge_r & ~in_v & prev_r));
    assign w1c     = (wr && ofs == 6'h05) ? (wdat & wmask) : '0;
    assign unused  = &{1'b0, wbs_adr_i[1:0], wbs_dat_i, lane};

    // Ack is gated by reset so a pending cycle is dropped in the reset cycle itself
    assign wbs_ack_o = ack_r & ~wb_rst_i;
    assign wbs_dat_o = wbs_ack_o ? rd : '0;
    assign io_out    = out_r;
    assign io_oeb    = {NGPIO{wb_rst_i}} | ~dir_r;

    // Bus handshake, register file, synchroniser and sticky edge flags (set wins over W1C)
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_r  <= 1'b0;
            out_r  <= '0;
            dir_r  <= '0;
            ie_r   <= '0;
            edge_r <= '0;
            stat_r <= '0;
            prev_r <= '0;
            sync_r <= '0;
        end else begin
            ack_r  <= hit_bus & ~ack_r;
            sync_r <= {sync_r[(SYNC_STAGES-1)*NGPIO-1:0], io_in};
            prev_r <= in_v;
            stat_r <= (stat_r & ~w1c) | hit;
            if (wr && ofs == 6'h00) out_r  <= (out_r  & ~wmask) | (wdat & wmask);
            if (wr && ofs == 6'h01) dir_r  <= (dir_r  & ~wmask) | (wdat & wmask);
            if (wr && ofs == 6'h03) ie_r   <= (ie_r   & ~wmask) | (wdat & wmask);
            if (wr && ofs == 6'h04) edge_r <= (edge_r & ~wmask) | (wdat & wmask);
        end
    end

    // Read mux; unmapped offsets and bits above NGPIO read zero
    always_comb begin
        rd = '0;
        rd[NGPIO-1:0] = ofs == 6'h00 ? out_r  :
                        ofs == 6'h01 ? dir_r  :
                        ofs == 6'h02 ? in_v   :
                        ofs == 6'h03 ? ie_r   :
                        ofs == 6'h04 ? edge_r :
                        ofs == 6'h05 ? stat_r : '0;
    end

    // Interrupt line k collects enabled pending pins i with i % NIRQ == k
    always_comb begin
        irq = '0;
        for (int k = 0; k < NIRQ; k++)
            for (int i = 0; i < NGPIO; i++)
                if (i % NIRQ == k) irq[k] = irq[k] | (stat_r[i] & ie_r[i]);
    end
endmodule

// File: tb/tb_subservient_gpio_bank.sv
// tb_subservient_gpio_bank: directed self-checking bench for the GPIO bank
module tb_subservient_gpio_bank;
    localparam logic [31:0] BASE = 32'h3000_0000;
    logic        clk = 1'b0, rst = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = '0;
    logic [31:0] dat_i = '0, adr = '0, dat_o;
    logic        ack;
    logic [7:0]  io_in = '0, io_out, io_oeb;
    logic [2:0]  irq;
    int          tests = 0, fails = 0;

    subservient_gpio_bank dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc),
        .wbs_we_i(we), .wbs_sel_i(sel), .wbs_dat_i(dat_i), .wbs_adr_i(adr),
        .wbs_ack_o(ack), .wbs_dat_o(dat_o), .io_in(io_in), .io_out(io_out),
        .io_oeb(io_oeb), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic idle();
        cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; dat_i = 0;
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        @(negedge clk);
        cyc = 1; stb = 1; we = 1; adr = a; dat_i = d; sel = s;
        for (n = 0; n < 16 && !ack; n++) @(negedge clk);
        tests++;
        if (!ack) begin fails++; $display("FAIL write_ack_timeout adr=%h got ack=0 want 1", a); end
        @(posedge clk); #1 idle();
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
        int n;
        @(negedge clk);
        cyc = 1; stb = 1; we = 0; adr = a; sel = 4'hF;
        for (n = 0; n < 16 && !ack; n++) @(negedge clk);
        tests++;
        if (!ack) begin fails++; $display("FAIL read_ack_timeout adr=%h got ack=0 want 1", a); end
        d = dat_o;
        @(posedge clk); #1 idle();
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst = 1; idle();
        repeat (3) @(negedge clk);
        tests++; if (io_oeb !== 8'hFF) begin fails++; $display("FAIL reset_oeb got %h want ff", io_oeb); end
        tests++; if (io_out !== 8'h00) begin fails++; $display("FAIL reset_out got %h want 00", io_out); end
        tests++; if (irq !== 3'b000) begin fails++; $display("FAIL reset_irq got %b want 000", irq); end
        tests++; if (ack !== 1'b0) begin fails++; $display("FAIL reset_ack got %b want 0", ack); end
        rst = 0;
        for (int i = 0; i < 6; i++) begin
            wb_read(BASE + 32'(i * 4), d);
            tests++; if (d !== 32'h0) begin fails++; $display("FAIL reset_read off=%0h got %h want 0", i * 4, d); end
        end
    endtask

    task automatic test_outputs();
        logic [31:0] d;
        wb_write(BASE + 32'h04, 32'h0F, 4'hF);
        wb_write(BASE + 32'h00, 32'hA5, 4'hF);
        tests++; if (io_oeb !== 8'hF0) begin fails++; $display("FAIL out_oeb got %h want f0", io_oeb); end
        tests++; if (io_out !== 8'hA5) begin fails++; $display("FAIL out_val got %h want a5", io_out); end
        wb_write(BASE + 32'h00, 32'h3C, 4'b0010);
        wb_read(BASE + 32'h00, d);
        tests++; if (d !== 32'hA5) begin fails++; $display("FAIL out_sel got %h want a5", d); end
        wb_read(BASE + 32'h04, d);
        tests++; if (d !== 32'h0F) begin fails++; $display("FAIL dir_read got %h want 0f", d); end
    endtask

    task automatic test_sync();
        logic [31:0] d;
        @(negedge clk);
        io_in = 8'h81;
        cyc = 1; stb = 1; we = 0; adr = BASE + 32'h08; sel = 4'hF;
        @(negedge clk);
        tests++; if ({ack, dat_o} !== {1'b1, 32'h0}) begin fails++; $display("FAIL sync_early got ack=%b dat=%h want ack=1 dat=0", ack, dat_o); end
        @(posedge clk); #1 idle();
        wb_read(BASE + 32'h08, d);
        tests++; if (d !== 32'h81) begin fails++; $display("FAIL sync_late got %h want 81", d); end
    endtask

    task automatic test_rise();
        logic [31:0] d;
        io_in = 8'h00;
        repeat (5) @(negedge clk);
        wb_write(BASE + 32'h0C, 32'h01, 4'hF);
        wb_write(BASE + 32'h10, 32'h01, 4'hF);
        @(negedge clk); io_in = 8'h01;
        repeat (2) @(negedge clk);
        tests++; if (irq !== 3'b000) begin fails++; $display("FAIL rise_early got %b want 000", irq); end
        @(negedge clk);
        tests++; if (irq !== 3'b001) begin fails++; $display("FAIL rise_irq got %b want 001", irq); end
        wb_read(BASE + 32'h14, d);
        tests++; if (d !== 32'h01) begin fails++; $display("FAIL rise_stat got %h want 01", d); end
        wb_write(BASE + 32'h14, 32'h01, 4'hF);
        tests++; if (irq !== 3'b000) begin fails++; $display("FAIL rise_w1c got %b want 000", irq); end
        io_in = 8'h09;
        repeat (5) @(negedge clk);
        wb_read(BASE + 32'h14, d);
        tests++; if (d !== 32'h00) begin fails++; $display("FAIL rise_masked got %h want 00", d); end
    endtask

    task automatic test_fall();
        logic [31:0] d;
        wb_write(BASE + 32'h0C, 32'h02, 4'hF);
        wb_write(BASE + 32'h10, 32'h00, 4'hF);
        io_in = 8'h0B;
        repeat (5) @(negedge clk);
        tests++; if (irq !== 3'b000) begin fails++; $display("FAIL fall_wrong_edge got %b want 000", irq); end
        @(negedge clk); io_in = 8'h09;
        repeat (3) @(negedge clk);
        tests++; if (irq !== 3'b010) begin fails++; $display("FAIL fall_irq got %b want 010", irq); end
        io_in = 8'h0B;
        repeat (5) @(negedge clk);
        @(negedge clk); io_in = 8'h09;
        @(negedge clk);
        cyc = 1; stb = 1; we = 1; adr = BASE + 32'h14; dat_i = 32'h02; sel = 4'hF;
        @(negedge clk);
        tests++; if (ack !== 1'b1) begin fails++; $display("FAIL race_ack got %b want 1", ack); end
        @(posedge clk); #1 idle();
        wb_read(BASE + 32'h14, d);
        tests++; if (d !== 32'h02) begin fails++; $display("FAIL race_stat got %h want 02", d); end
        wb_write(BASE + 32'h0C, 32'h00, 4'hF);
        wb_read(BASE + 32'h14, d);
        tests++; if (d !== 32'h02) begin fails++; $display("FAIL ie_clear_stat got %h want 02", d); end
        tests++; if (irq !== 3'b000) begin fails++; $display("FAIL ie_clear_irq got %b want 000", irq); end
    endtask

    task automatic test_bus();
        logic [31:0] d;
        logic [3:0]  pat;
        int          n;
        pat = 4'b1010;
        @(negedge clk);
        cyc = 1; stb = 1; we = 0; adr = BASE; sel = 4'hF;
        for (int i = 0; i < 4; i++) begin
            tests++; if (ack !== pat[i]) begin fails++; $display("FAIL held_ack cyc=%0d got %b want %b", i, ack, pat[i]); end
            @(negedge clk);
        end
        idle();
        @(negedge clk);
        cyc = 1; stb = 1; adr = 32'h3000_0100; sel = 4'hF;
        n = 0;
        repeat (8) begin @(negedge clk); if (ack) n++; end
        tests++; if (n !== 0) begin fails++; $display("FAIL off_window_acks got %0d want 0", n); end
        idle();
        wb_read(BASE + 32'h1C, d);
        tests++; if (d !== 32'h0) begin fails++; $display("FAIL unmapped got %h want 0", d); end
        @(negedge clk);
        cyc = 1; stb = 1; we = 1; adr = BASE; dat_i = 32'hFF; sel = 4'hF;
        @(negedge clk);
        rst = 1;
        #1;
        tests++; if (ack !== 1'b0) begin fails++; $display("FAIL rst_ack got %b want 0", ack); end
        @(posedge clk); #1 idle();
        @(negedge clk); rst = 0;
        wb_read(BASE, d);
        tests++; if (d !== 32'h0) begin fails++; $display("FAIL rst_write got %h want 0", d); end
    endtask

    initial begin
        test_reset();
        test_outputs();
        test_sync();
        test_rise();
        test_fall();
        test_bus();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
